// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 UART receiver, 16x oversampled on brg_stb_i, LSb first, with holding register flags.
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
`timescale 1ns/1ps
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       brg_stb_i,
    input  logic       rxd_i,
    input  logic       re_i,
    output logic [7:0] dout_o,
    output logic       rdy_o,
    output logic       ovr_o,
    output logic       ferr_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [3:0]             tick_q;
    logic [2:0]             bit_q;
    logic [7:0]             shift_q;
    logic [7:0]             dout_q;
    logic                   rdy_q;
    logic                   ovr_q;
    logic                   ferr_q;
    logic                   busy_q;
    logic                   rxd_s;
    logic                   sample_d;
    logic                   ack_d;

    // NOTE: the synchroniser resets to the idle (high) line level so reset release never looks like a start bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd_i};
        end
    end

    assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] START_TICK = 4'd8;
    logic [1:0] hist_q;

    // History holds the two strobes before the decision tick (6,7 in START, 13,14 in DATA/STOP).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q <= 2'b11;
        end else if (brg_stb_i) begin
            hist_q <= {hist_q[0], rxd_s};
        end
    end

    assign sample_d = (hist_q[1] & hist_q[0]) | ((hist_q[1] | hist_q[0]) & rxd_s);
`else
    localparam logic [3:0] START_TICK = 4'd7;
    assign sample_d = rxd_s;
`endif

    assign ack_d = re_i & rdy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            rdy_q   <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: the read acknowledge is written first so a byte completing in the same cycle overrides it.
            if (ack_d) begin
                rdy_q <= 1'b0;
                ovr_q <= 1'b0;
            end
            if (brg_stb_i) begin
                tick_q <= tick_q + 4'd1;
                unique case (state_q)
                    IDLE: begin
                        if (!rxd_s) begin
                            state_q <= START;
                            tick_q  <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_q == START_TICK) begin
                            tick_q <= '0;
                            if (!sample_d) begin
                                state_q <= DATA;
                                bit_q   <= '0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        if (tick_q == 4'd15) begin
                            shift_q <= {sample_d, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                state_q <= STOP;
                                tick_q  <= '0;
                            end
                        end
                    end
                    STOP: begin
                        if (tick_q == 4'd15) begin
                            dout_q <= shift_q;
                            rdy_q  <= 1'b1;
                            ferr_q <= ~sample_d;
                            ovr_q  <= (ovr_q | rdy_q) & ~re_i;
                            tick_q <= '0;
                            if (sample_d) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= BRK;
                            end
                        end
                    end
                    BRK: begin
                        // A held-low line must return high before another start edge is accepted.
                        if (rxd_s) begin
                            state_q <= IDLE;
                            tick_q  <= '0;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dout_o = dout_q;
    assign rdy_o  = rdy_q;
    assign ovr_o  = ovr_q;
    assign ferr_o = ferr_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames on a 16x strobe every 4 clocks, checked against a
// byte-level model of the holding register and its ready/overrun/framing flags.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BIT_CLKS   = 64;
    localparam int FRAME_CLKS = 10 * BIT_CLKS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       brg_stb = 1'b0;
    logic       rxd = 1'b1;
    logic       re = 1'b0;
    logic [7:0] dout;
    logic       rdy;
    logic       ovr;
    logic       ferr;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] m_dout;
    logic       m_rdy;
    logic       m_ovr;
    logic       m_ferr;

    uart_rx #(.SYNC_STAGES(2)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .brg_stb_i(brg_stb),
        .rxd_i    (rxd),
        .re_i     (re),
        .dout_o   (dout),
        .rdy_o    (rdy),
        .ovr_o    (ovr),
        .ferr_o   (ferr),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) brg_stb = (cyc % 4 == 0);

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Byte-level reference model of the CPU-visible holding register.
    task automatic model_reset();
        m_dout = 8'h00;
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic model_read();
        if (m_rdy) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop);
        m_ovr  = m_ovr | m_rdy;
        m_rdy  = 1'b1;
        m_dout = b;
        m_ferr = ~stop;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_dout"}, dout, m_dout);
        check({tag, "_rdy"},  {7'b0, rdy},  {7'b0, m_rdy});
        check({tag, "_ovr"},  {7'b0, ovr},  {7'b0, m_ovr});
        check({tag, "_ferr"}, {7'b0, ferr}, {7'b0, m_ferr});
    endtask

    task automatic drive_line(input logic level, input int n);
        rxd = level;
        repeat (n) @(negedge clk);
    endtask

    task automatic read_byte();
        re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        @(negedge clk);
    endtask

    // Drives the first n_clks of a frame; re pulses in cycle re_at; rise_at = first cycle rdy is seen high.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int re_at,
                              input int n_clks, output int rise_at);
        logic [9:0] bits;
        bits    = {stop, b, 1'b0};
        rise_at = -1;
        while (cyc % 4 != 0) @(negedge clk);
        for (int c = 0; c < n_clks; c++) begin
            rxd = bits[c / BIT_CLKS];
            re  = (c == re_at);
            @(negedge clk);
            if (rise_at < 0 && rdy === 1'b1) rise_at = c;
        end
        re = 1'b0;
    endtask

    task automatic send_idle(input logic [7:0] b, input logic stop);
        int r;
        send_frame(b, stop, -1, FRAME_CLKS, r);
        drive_line(1'b1, 16);
    endtask

    initial begin
        int         rise;
        int         r2;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       stop;

        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        check("reset_busy", {7'b0, busy}, 8'h00);
        rst = 1'b0;
        drive_line(1'b1, 32);

        send_idle(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b1);
        check_all("a5");
        check("a5_busy", {7'b0, busy}, 8'h00);
        read_byte();
        model_read();
        check_all("a5_read");

        drive_line(1'b0, 20);
        check("glitch_busy_hi", {7'b0, busy}, 8'h01);
        drive_line(1'b1, BIT_CLKS);
        check("glitch_busy_lo", {7'b0, busy}, 8'h00);
        check_all("glitch");

        send_idle(8'h3C, 1'b1);
        model_frame(8'h3C, 1'b1);
        send_idle(8'hC3, 1'b1);
        model_frame(8'hC3, 1'b1);
        check_all("overrun");
        read_byte();
        model_read();
        check_all("overrun_read");

        send_frame(8'h55, 1'b0, -1, FRAME_CLKS, rise);
        model_frame(8'h55, 1'b0);
        drive_line(1'b0, 3 * BIT_CLKS);
        check("brk_busy", {7'b0, busy}, 8'h01);
        check_all("brk");
        drive_line(1'b1, BIT_CLKS);
        check("brk_exit_busy", {7'b0, busy}, 8'h00);
        check_all("brk_exit");
        read_byte();
        model_read();
        send_idle(8'h0F, 1'b1);
        model_frame(8'h0F, 1'b1);
        check_all("after_brk");
        read_byte();
        model_read();

        // Same phase and length for both frames, so the completion cycle repeats exactly.
        b1 = 8'($urandom);
        b2 = b1 ^ 8'hFF;
        send_frame(b1, 1'b1, -1, FRAME_CLKS, rise);
        drive_line(1'b1, 16);
        model_frame(b1, 1'b1);
        check("rise_seen", {7'b0, (rise >= 0)}, 8'h01);
        send_frame(b2, 1'b1, rise, FRAME_CLKS, r2);
        drive_line(1'b1, 16);
        model_read();
        model_frame(b2, 1'b1);
        check_all("simul");

        send_frame(8'h81, 1'b1, -1, 5 * BIT_CLKS + 32, rise);
        check("mid_busy", {7'b0, busy}, 8'h01);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst_busy", {7'b0, busy}, 8'h00);
        @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        drive_line(1'b1, 32);
        send_idle(8'h81, 1'b1);
        model_frame(8'h81, 1'b1);
        check_all("after_rst");

        for (int i = 0; i < 8; i++) begin
            b1   = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_idle(b1, stop);
            model_frame(b1, stop);
            check_all($sformatf("rand%0d", i));
            check($sformatf("rand%0d_busy", i), {7'b0, busy}, 8'h00);
            if ($urandom_range(0, 1) == 1) begin
                read_byte();
                model_read();
                check_all($sformatf("rand%0d_read", i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
